// File: rtl/cpu_alu_pkg.sv
// Shared ALU definitions: CLA group width, CPU data width, ALU opcode and the
// 4-bit carry-lookahead group function used by every pipeline stage.
package cpu_alu_pkg;

  localparam int CLA_GROUP_W = 4;
  localparam int DATA_W      = 12;

  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } alu_op_t;

  // One 4-bit carry-lookahead group: returns {carry_out, sum[3:0]}.
  // All four internal carries come from generate/propagate terms, so no
  // carry ripples through the group.
  function automatic logic [4:0] cla4(input logic [3:0] x,
                                      input logic [3:0] y,
                                      input logic       ci);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = x & y;
    p    = x ^ y;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return {c[4], p ^ c[3:0]};
  endfunction

endpackage

// File: rtl/cla_pipe_stage.sv
// One register stage of the add/sub pipeline. Stage K resolves G chained
// 4-bit CLA groups covering bits [4G(K+1)-1 : 4GK] using the carry handed
// over by the previous stage. Operands travel with the beat so later stages
// still see their slices, and the partial sum accumulates the low slices
// already resolved (skew matching).
module cla_pipe_stage
  import cpu_alu_pkg::*;
#(
  parameter int N = 16,
  parameter int G = 1,
  parameter int K = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         advance_i,
  input  logic         valid_i,
  input  logic         carry_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic [N-1:0] s_i,
  output logic         valid_o,
  output logic         carry_o,
  output logic [N-1:0] a_o,
  output logic [N-1:0] b_o,
  output logic [N-1:0] s_o
);

  localparam int LO = CLA_GROUP_W * G * K;

  logic         valid_q;
  logic         carry_q;
  logic [N-1:0] a_q;
  logic [N-1:0] b_q;
  logic [N-1:0] s_q;
  logic         carry_d;
  logic [N-1:0] s_d;
  logic [4:0]   grp;

  // Resolve this stage's groups, rippling the carry group to group.
  always_comb begin
    s_d     = s_i;
    carry_d = carry_i;
    grp     = '0;
    for (int g = 0; g < G; g++) begin
      grp = cla4(a_i[LO + CLA_GROUP_W*g +: CLA_GROUP_W],
                 b_i[LO + CLA_GROUP_W*g +: CLA_GROUP_W],
                 carry_d);
      s_d[LO + CLA_GROUP_W*g +: CLA_GROUP_W] = grp[3:0];
      carry_d = grp[4];
    end
  end

  // Stage register: shifts only on the global advance, bubbles included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
    end else if (advance_i) begin
      valid_q <= valid_i;
      carry_q <= carry_d;
      a_q     <= a_i;
      b_q     <= b_i;
      s_q     <= s_d;
    end
  end

  assign valid_o = valid_q;
  assign carry_o = carry_q;
  assign a_o     = a_q;
  assign b_o     = b_q;
  assign s_o     = s_q;

endmodule

// File: rtl/pipelined_cla_addsub.sv
// Pipelined N-bit add/subtract unit with valid/ready stream interface.
// STAGES copies of cla_pipe_stage pass the carry forward one stage per cycle;
// the whole pipe stalls together when the output beat is not taken.
// Optional macro PIPELINED_CLA_SATURATE_EN: saturate sum on signed overflow
// (cout/ovf stay raw, zero follows the saturated sum).
module pipelined_cla_addsub
  import cpu_alu_pkg::*;
#(
  parameter int N      = 16,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         zero
);

  localparam int G = N / (CLA_GROUP_W * STAGES);

  if (N % (CLA_GROUP_W * STAGES) != 0) begin : g_bad_width
    $fatal(1, "pipelined_cla_addsub: N must be a multiple of 4*STAGES");
  end

  alu_op_t      op;
  logic         advance;
  logic         v_w     [STAGES+1];
  logic         carry_w [STAGES+1];
  logic [N-1:0] a_w     [STAGES+1];
  logic [N-1:0] b_w     [STAGES+1];
  logic [N-1:0] s_w     [STAGES+1];
  logic [N-1:0] raw_sum;
  logic         msb_cin;

  assign op       = alu_op_t'(sub);
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Subtraction is A + ~B + 1; the inversion and forced carry happen once here.
  assign v_w[0]     = in_valid;
  assign carry_w[0] = (op == SUB) ? 1'b1 : cin;
  assign a_w[0]     = a;
  assign b_w[0]     = (op == SUB) ? ~b : b;
  assign s_w[0]     = '0;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    cla_pipe_stage #(
      .N (N),
      .G (G),
      .K (k)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .advance_i (advance),
      .valid_i   (v_w[k]),
      .carry_i   (carry_w[k]),
      .a_i       (a_w[k]),
      .b_i       (b_w[k]),
      .s_i       (s_w[k]),
      .valid_o   (v_w[k+1]),
      .carry_o   (carry_w[k+1]),
      .a_o       (a_w[k+1]),
      .b_o       (b_w[k+1]),
      .s_o       (s_w[k+1])
    );
  end

  assign out_valid = v_w[STAGES];
  assign raw_sum   = s_w[STAGES];
  assign cout      = carry_w[STAGES];

  // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ c_in.
  assign msb_cin = a_w[STAGES][N-1] ^ b_w[STAGES][N-1] ^ raw_sum[N-1];
  assign ovf     = msb_cin ^ cout;

`ifdef PIPELINED_CLA_SATURATE_EN
  assign sum = !ovf ? raw_sum
             : (a_w[STAGES][N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}});
`else
  assign sum = raw_sum;
`endif

  // Gated by valid so the flag reads 0 out of reset and between beats.
  assign zero = out_valid && (sum == '0);

endmodule
